// File: rtl/ahb3lite_master_cmd_if.sv
// ahb3lite_master_cmd_if
// Groups the local command/response port and the AHB3-Lite master-side bus
// of ahb3lite_master_cmd.
//   master modport : seen from the initiator (command in, response out,
//                    AHB address/control/write data out, HRDATA/HREADY/HRESP in)
//   slave modport  : seen from the environment (command issuer + AHB slave)
interface ahb3lite_master_cmd_if;
    // command / response
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WRITE;
    logic [31:0] CMD_ADDR;
    logic [1:0]  CMD_SIZE;
    logic [31:0] CMD_WDATA;
    logic        RSP_VALID;
    logic        RSP_ERR;
    logic [31:0] RSP_RDATA;
    // AHB3-Lite
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
        input  HRDATA, HREADY, HRESP,
        output CMD_READY, RSP_VALID, RSP_ERR, RSP_RDATA,
        output HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
        output HRDATA, HREADY, HRESP,
        input  CMD_READY, RSP_VALID, RSP_ERR, RSP_RDATA,
        input  HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
    );
endinterface

// File: rtl/ahb3lite_master_cmd.sv
// ahb3lite_master_cmd
// Command-driven AHB3-Lite initiator: each accepted valid/ready command becomes
// one single, non-pipelined AHB transfer followed by a one-cycle response pulse.
// Misaligned or size-3 commands are answered with an error without touching
// the bus.
//
// Ports:
//   CLK     clock
//   RESETn  synchronous active-low reset
//   bus     ahb3lite_master_cmd_if.master (command, response and AHB signals)
//
// Parameters:
//   HPROT_VAL  constant HPROT value
//   TIMEOUT    HREADY-low cycle limit (>= 2), only with the timeout option
//
// Optional feature: define AHB3LITE_MASTER_TIMEOUT_EN to abort a transfer whose
// slave holds HREADY low for TIMEOUT cycles (RSP_ERR=1, RSP_RDATA=32'hdeadbeef).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | CMD_READY high, waiting for a command
// ST_ADDR | NONSEQ address phase on the bus, waiting for HREADY
// ST_DATA | data phase, HTRANS back to IDLE, waiting for HREADY
// ST_RESP | RSP_VALID pulse, back to idle next cycle
module ahb3lite_master_cmd #(
    parameter logic [3:0]  HPROT_VAL = 4'b0011,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    ahb3lite_master_cmd_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("ahb3lite_master_cmd: TIMEOUT must be >= 2");
    end

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_haddr;
    logic [31:0] r_hwdata;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [1:0]  r_htrans;
    logic [31:0] r_wdata_rep;

    logic        w_accept;
    logic        w_illegal;
    logic [31:0] w_wdata_rep;

`ifdef AHB3LITE_MASTER_TIMEOUT_EN
    // Down-counter loaded with TIMEOUT-1 on entry to ADDR/DATA; the stall
    // cycle that finds it at zero is the TIMEOUT-th one.
    localparam int unsigned     TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    logic [TMR_W-1:0] r_tmr;
    logic             w_tmr_done;
    assign w_tmr_done = (r_tmr == '0);
`endif

    assign w_accept = bus.CMD_VALID & r_cmd_ready;

    // Alignment check and lane replication of the write data.
    always_comb begin
        w_illegal   = 1'b0;
        w_wdata_rep = bus.CMD_WDATA;
        case (bus.CMD_SIZE)
            2'd0: w_wdata_rep = {4{bus.CMD_WDATA[7:0]}};
            2'd1: begin
                w_illegal   = bus.CMD_ADDR[0];
                w_wdata_rep = {2{bus.CMD_WDATA[15:0]}};
            end
            2'd2:    w_illegal = |bus.CMD_ADDR[1:0];
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_haddr     <= '0;
            r_hwdata    <= '0;
            r_hwrite    <= 1'b0;
            r_hsize     <= '0;
            r_htrans    <= HTRANS_IDLE;
            r_wdata_rep <= '0;
`ifdef AHB3LITE_MASTER_TIMEOUT_EN
            r_tmr       <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        if (w_illegal) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_haddr     <= bus.CMD_ADDR;
                            r_hwrite    <= bus.CMD_WRITE;
                            r_hsize     <= {1'b0, bus.CMD_SIZE};
                            r_htrans    <= HTRANS_NONSEQ;
                            r_wdata_rep <= w_wdata_rep;
                            r_state     <= ST_ADDR;
`ifdef AHB3LITE_MASTER_TIMEOUT_EN
                            r_tmr       <= TMR_LOAD;
`endif
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.HREADY) begin
                        r_htrans <= HTRANS_IDLE;
                        r_hwdata <= r_hwrite ? r_wdata_rep : '0;
                        r_state  <= ST_DATA;
`ifdef AHB3LITE_MASTER_TIMEOUT_EN
                        r_tmr    <= TMR_LOAD;
                    end else if (w_tmr_done) begin
                        r_htrans    <= HTRANS_IDLE;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'hdeadbeef;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
`endif
                    end
                end
                ST_DATA: begin
                    // First cycle of a two-cycle ERROR has HREADY low and is
                    // just another wait; HTRANS is already IDLE.
                    if (bus.HREADY) begin
                        r_rsp_rdata <= r_hwrite ? '0 : bus.HRDATA;
                        r_rsp_err   <= bus.HRESP;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
`ifdef AHB3LITE_MASTER_TIMEOUT_EN
                    end else if (w_tmr_done) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'hdeadbeef;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
`endif
                    end
                end
                ST_RESP: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.CMD_READY = r_cmd_ready;
    assign bus.RSP_VALID = r_rsp_valid;
    assign bus.RSP_ERR   = r_rsp_err;
    assign bus.RSP_RDATA = r_rsp_rdata;
    assign bus.HADDR     = r_haddr;
    assign bus.HWDATA    = r_hwdata;
    assign bus.HWRITE    = r_hwrite;
    assign bus.HSIZE     = r_hsize;
    assign bus.HTRANS    = r_htrans;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;
endmodule

// File: doc/ahb3lite_master_cmd.md
Name: ahb3lite_master_cmd

Overview:
- Simple command-driven AHB3-Lite initiator. A local valid/ready command port is turned into single, non-pipelined AHB transfers.
- Drives the bus toward AHB3-Lite slaves such as the team's CSR slave. Serves as the bus master for bring-up/debug engines and small controllers.
- One transfer outstanding at a time. Each command produces exactly one response pulse, unless reset intervenes.

Parameters:
- HPROT_VAL, 4'b0011, constant HPROT driven on every transfer (data, privileged).
- TIMEOUT, 256, HREADY-low cycle limit before abort; used only with the optional feature; must be >= 2.

Ports:
- CLK  input  1  clock.
- RESETn  input  1  reset; synchronous and active-low.
- CMD_VALID  input  1  command valid.
- CMD_READY  output  1  command accepted when CMD_VALID & CMD_READY are both high.
- CMD_WRITE  input  1  1 = write, 0 = read.
- CMD_ADDR  input  32  byte address.
- CMD_SIZE  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- CMD_WDATA  input  32  write data, right-justified.
- RSP_VALID  output  1  one-cycle response pulse.
- RSP_ERR  output  1  error flag, qualified by RSP_VALID.
- RSP_RDATA  output  32  raw 32-bit lane data from HRDATA, qualified by RSP_VALID.
- HADDR  output  32  AHB address.
- HWDATA  output  32  AHB write data.
- HWRITE  output  1  AHB write.
- HSIZE  output  3  AHB size.
- HBURST  output  3  constant SINGLE (3'b000).
- HPROT  output  4  constant HPROT_VAL.
- HTRANS  output  2  IDLE or NONSEQ only.
- HMASTLOCK  output  1  constant 0.
- HRDATA  input  32  AHB read data.
- HREADY  input  1  AHB ready.
- HRESP  input  1  AHB response (0 = OKAY, 1 = ERROR).

Behaviour:
- All state is registered. States are IDLE, ADDR, DATA and RESP.

Reset
- While RESETn=0, at the clock edge:
  - State becomes IDLE.
  - HTRANS=IDLE; HADDR, HWDATA, HWRITE, HSIZE = 0.
  - RSP_VALID, RSP_ERR = 0; RSP_RDATA = 0.
  - CMD_READY = 0.
- Reset mid-transfer drops the transfer and produces no response.
- CMD_READY=1 from the first cycle after RESETn returns high.

IDLE
- CMD_READY=1 in IDLE only.
- On accept, the command is checked for alignment:
  - Illegal if CMD_SIZE=3, or size=1 with ADDR[0]=1, or size=2 with ADDR[1:0]!=0.
  - Illegal command: no bus activity; go to RESP with RSP_ERR=1 and RSP_RDATA=0.
  - Legal command: register HADDR=CMD_ADDR, HWRITE, HSIZE={1'b0,CMD_SIZE}, HTRANS=NONSEQ; go to ADDR.
- Write data is latched for replication:
  - byte: {4{wdata[7:0]}}
  - halfword: {2{wdata[15:0]}}
  - word: as-is.

ADDR (address phase on the bus)
- Hold all address/control outputs while HREADY=0.
- When HREADY=1:
  - HTRANS becomes IDLE.
  - HWDATA is driven with the replicated data (writes; reads drive 0).
  - Go to DATA.

DATA (data phase)
- Hold HWDATA while HREADY=0.
- ERROR response: cycle 1 of HRESP=1 with HREADY=0 is a wait. HTRANS is already IDLE, so nothing extra is required.
- On HREADY=1:
  - Capture RSP_RDATA=HRDATA for reads and 0 for writes.
  - Capture RSP_ERR=HRESP.
  - Go to RESP.

RESP
- RSP_VALID=1 for exactly one cycle. No back-pressure is applied; the consumer must take the response.
- Next state is IDLE.

Timing and throughput
- Zero-wait-state latency:
  - accept at cycle 0;
  - NONSEQ at cycle 1;
  - data phase at cycle 2;
  - RSP_VALID at cycle 3.
- Each HREADY-low cycle adds 1 cycle.
- Maximum throughput is 1 command per 4 cycles.
- HADDR/HWRITE/HSIZE retain the last value when idle.

Optional Feature:
Macro AHB3LITE_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ADDR or DATA and counts cycles with HREADY=0 in those states.
  - When the count reaches TIMEOUT, the transfer aborts:
    - HTRANS=IDLE;
    - go to RESP with RSP_ERR=1 and RSP_RDATA=32'hdeadbeef.
  - A late HREADY after the abort is ignored.
- Not defined: no counter; the master waits indefinitely. TIMEOUT is unused.

Test Plan:
- Word write 0xCAFEF00D to 0x40000004, HREADY always 1 -> NONSEQ at cycle 1 with HSIZE=2, HWRITE=1; HWDATA=0xCAFEF00D at cycle 2; RSP_VALID at cycle 3 with RSP_ERR=0; CMD_READY low in cycles 1-3.
- Byte write 0xA5 to 0x40000003 -> HSIZE=0, HADDR=0x40000003, HWDATA=0xA5A5A5A5.
- Word read from 0x10, slave holds HREADY=0 for 3 cycles in data phase then returns HRDATA=0x12345678 -> HWDATA held, RSP_VALID at cycle 6 with RSP_RDATA=0x12345678.
- Slave two-cycle ERROR on a read -> RSP_ERR=1, HTRANS stays IDLE after the address phase. Separately, halfword command to 0x1 and a size-3 command -> no NONSEQ issued, RSP_ERR=1 and RSP_RDATA=0 one cycle after accept.
- RESETn low during DATA with HREADY=0 -> no RSP_VALID, HTRANS=IDLE; after release CMD_READY=1 and a fresh word read completes normally.
- With AHB3LITE_MASTER_TIMEOUT_EN, TIMEOUT=8, HREADY held 0 -> abort after 8 stall cycles with RSP_ERR=1 and RSP_RDATA=0xdeadbeef; without the macro, no response until HREADY=1.
